// File: rtl/ram_clr_if.sv
// ---------------------------------------------------------------------------
// ram_clr_if -- access/status bundle for the self-clearing RAM.
//
// Signals
//   EN, WE, ADDR, Din : user access request (EN qualifies WE)
//   CLR               : request to zero the whole array
//   Dout, DVALID      : registered read data and its one-cycle valid pulse
//   BUSY, DONE        : clear engine owns the array / clear just finished
//
// Modports
//   master : the side issuing accesses (drives requests, observes results)
//   slave  : the RAM itself
// ---------------------------------------------------------------------------
interface ram_clr_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 10
);
   logic                  EN;
   logic                  WE;
   logic [ADDR_WIDTH-1:0] ADDR;
   logic [DATA_WIDTH-1:0] Din;
   logic                  CLR;
   logic [DATA_WIDTH-1:0] Dout;
   logic                  DVALID;
   logic                  BUSY;
   logic                  DONE;

   modport master (
      output EN, WE, ADDR, Din, CLR,
      input  Dout, DVALID, BUSY, DONE
   );

   modport slave (
      input  EN, WE, ADDR, Din, CLR,
      output Dout, DVALID, BUSY, DONE
   );
endinterface

// File: rtl/ram_clr.sv
// ---------------------------------------------------------------------------
// ram_clr -- single-port RAM with a built-in sequential clear engine.
//
// After reset release, and whenever CLR is seen while idle, the engine writes
// zero to every word, one word per cycle, holding BUSY high for exactly
// MEM_SIZE cycles and pulsing DONE on the first idle cycle afterwards. While
// idle the array serves one read or write per cycle with one cycle of read
// latency. Addresses at or beyond MEM_SIZE read as zero and drop writes.
// MEM_SIZE must lie in 2 .. 2**ADDR_WIDTH.
//
// Ports
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset; forces the clear engine to restart
//   bus   : ram_clr_if.slave (EN, WE, ADDR, Din, CLR in; Dout, DVALID,
//           BUSY, DONE out)
//
// Parameters
//   ADDR_WIDTH, DATA_WIDTH, MEM_SIZE
//   RDW_MODE : 0 = Dout untouched by writes, 1 = writes also drive Dout
// ---------------------------------------------------------------------------
module ram_clr #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 10,
   parameter int MEM_SIZE   = 256,
   parameter int RDW_MODE   = 0
) (
   input  logic     CLK,
   input  logic     RST_N,
   ram_clr_if.slave bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] CNT_LAST   = ADDR_WIDTH'(MEM_SIZE - 1);
   localparam logic [ADDR_WIDTH:0]   MEM_SIZE_W = (ADDR_WIDTH + 1)'(MEM_SIZE);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE-1];

   logic                  in_range;
   logic                  acc;
   logic                  clr_last;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   logic [DATA_WIDTH-1:0] dout_p1;
   logic                  dvalid_p1;
   logic                  done_p1;

   // Extra leading bit so MEM_SIZE == 2**ADDR_WIDTH still compares correctly.
   assign in_range = ({1'b0, bus.ADDR} < MEM_SIZE_W);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc       = 1'b0;
      clr_last  = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = bus.ADDR;
      mem_wdata = bus.Din;
      case (state_q)
         IDLE: begin
            // CLR beats a simultaneous access: the access is simply dropped.
            if (bus.CLR) begin
               state_d = CLEAR;
            end else if (bus.EN) begin
               acc    = 1'b1;
               mem_we = bus.WE && in_range;
            end
         end
         CLEAR: begin
            // User inputs, including a repeated CLR, are ignored here.
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            if (cnt_q == CNT_LAST) begin
               clr_last = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   // Stage p0 -> p1: control state and registered read port
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= CLEAR;
         cnt_q     <= '0;
         dout_p1   <= '0;
         dvalid_p1 <= 1'b0;
         done_p1   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         done_p1   <= clr_last;
         dvalid_p1 <= acc && (!bus.WE || (RDW_MODE != 0));
         if (acc) begin
            if (!bus.WE) begin
               dout_p1 <= in_range ? mem[bus.ADDR] : '0;
            end else if (RDW_MODE != 0) begin
               dout_p1 <= bus.Din;
            end
         end
      end
   end

   // Array contents are never reset; only the clear engine zeroes them.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign bus.Dout   = dout_p1;
   assign bus.DVALID = dvalid_p1;
   assign bus.DONE   = done_p1;
   assign bus.BUSY   = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_clr.sv
// ---------------------------------------------------------------------------
// tb_ram_clr -- directed bench for ram_clr.
//
// Three instances share clock and reset:
//   u0 : defaults (256 words, RDW_MODE=0) -- main scenarios
//   u1 : RDW_MODE=1                       -- write-through behaviour
//   u2 : MEM_SIZE=200                     -- out-of-range access, short clear
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// that same point, so each check sees the result of the preceding edge.
// ---------------------------------------------------------------------------
module tb_ram_clr;

   logic CLK = 1'b0;
   logic RST_N;

   always #5 CLK = ~CLK;

   ram_clr_if #(.ADDR_WIDTH(8), .DATA_WIDTH(10)) b0 ();
   ram_clr_if #(.ADDR_WIDTH(8), .DATA_WIDTH(10)) b1 ();
   ram_clr_if #(.ADDR_WIDTH(8), .DATA_WIDTH(10)) b2 ();

   ram_clr #(.ADDR_WIDTH(8), .DATA_WIDTH(10), .MEM_SIZE(256), .RDW_MODE(0)) u0 (
      .CLK(CLK), .RST_N(RST_N), .bus(b0));
   ram_clr #(.ADDR_WIDTH(8), .DATA_WIDTH(10), .MEM_SIZE(256), .RDW_MODE(1)) u1 (
      .CLK(CLK), .RST_N(RST_N), .bus(b1));
   ram_clr #(.ADDR_WIDTH(8), .DATA_WIDTH(10), .MEM_SIZE(200), .RDW_MODE(0)) u2 (
      .CLK(CLK), .RST_N(RST_N), .bus(b2));

   int n_chk  = 0;
   int n_fail = 0;
   int busy0, busy2, done0, done2, dval0;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_all();
      b0.EN = 1'b0; b0.WE = 1'b0; b0.CLR = 1'b0; b0.ADDR = '0; b0.Din = '0;
      b1.EN = 1'b0; b1.WE = 1'b0; b1.CLR = 1'b0; b1.ADDR = '0; b1.Din = '0;
      b2.EN = 1'b0; b2.WE = 1'b0; b2.CLR = 1'b0; b2.ADDR = '0; b2.Din = '0;
   endtask

   // Runs a fixed window of cycles, counting BUSY cycles (sampled before each
   // edge) and DONE/DVALID pulses (sampled after each edge). Optionally
   // injects CLR and a write to address 5 on u0 at given window cycles.
   task automatic observe(input int ncyc, input int clr_at, input int wr_at);
      busy0 = 0; busy2 = 0; done0 = 0; done2 = 0; dval0 = 0;
      for (int i = 0; i < ncyc; i++) begin
         b0.CLR  = (i == clr_at);
         b0.EN   = (i == wr_at);
         b0.WE   = (i == wr_at);
         b0.ADDR = 8'd5;
         b0.Din  = 10'h155;
         busy0 += int'(b0.BUSY);
         busy2 += int'(b2.BUSY);
         tick();
         done0 += int'(b0.DONE);
         done2 += int'(b2.DONE);
         dval0 += int'(b0.DVALID);
      end
      b0.CLR = 1'b0; b0.EN = 1'b0; b0.WE = 1'b0;
   endtask

   task automatic read0(input logic [7:0] a, input logic [9:0] exp, input string tag);
      b0.EN = 1'b1; b0.WE = 1'b0; b0.ADDR = a;
      tick();
      check({tag, "_dout"}, 32'(b0.Dout), 32'(exp));
      check({tag, "_dvalid"}, 32'(b0.DVALID), 32'd1);
      b0.EN = 1'b0;
   endtask

   initial begin
      logic [7:0] rd_addr [3];
      rd_addr = '{8'd0, 8'd127, 8'd255};

      // Reset state
      idle_all();
      RST_N = 1'b0;
      repeat (3) tick();
      check("rst_busy",   32'(b0.BUSY),   32'd1);
      check("rst_dout",   32'(b0.Dout),   32'd0);
      check("rst_dvalid", 32'(b0.DVALID), 32'd0);
      check("rst_done",   32'(b0.DONE),   32'd0);

      // Automatic clear after release
      RST_N = 1'b1;
      observe(260, -1, -1);
      check("init_busy_len0", 32'(busy0), 32'd256);
      check("init_done0",     32'(done0), 32'd1);
      check("init_busy_len2", 32'(busy2), 32'd200);
      check("init_done2",     32'(done2), 32'd1);
      check("init_dvalid0",   32'(dval0), 32'd0);

      // Back-to-back reads after clear
      b0.EN = 1'b1; b0.WE = 1'b0;
      for (int k = 0; k < 3; k++) begin
         b0.ADDR = rd_addr[k];
         tick();
         check("init_rd_dout",   32'(b0.Dout),   32'd0);
         check("init_rd_dvalid", 32'(b0.DVALID), 32'd1);
      end
      b0.EN = 1'b0;
      tick();
      check("en_low_dvalid", 32'(b0.DVALID), 32'd0);

      // Write 0x2AB to 5 on u0/u1, 0x155 to 199 on u2
      b0.EN = 1'b1; b0.WE = 1'b1; b0.ADDR = 8'd5;   b0.Din = 10'h2AB;
      b1.EN = 1'b1; b1.WE = 1'b1; b1.ADDR = 8'd5;   b1.Din = 10'h2AB;
      b2.EN = 1'b1; b2.WE = 1'b1; b2.ADDR = 8'd199; b2.Din = 10'h155;
      tick();
      check("wr_m0_dvalid", 32'(b0.DVALID), 32'd0);
      check("wr_m0_dout",   32'(b0.Dout),   32'd0);
      check("wr_m1_dout",   32'(b1.Dout),   32'h2AB);
      check("wr_m1_dvalid", 32'(b1.DVALID), 32'd1);
      check("wr_s2_dvalid", 32'(b2.DVALID), 32'd0);

      // Read the just-written words
      b0.WE = 1'b0; b1.WE = 1'b0; b2.WE = 1'b0;
      tick();
      check("rdw_m0_dout",   32'(b0.Dout),   32'h2AB);
      check("rdw_m0_dvalid", 32'(b0.DVALID), 32'd1);
      check("rdw_m1_dout",   32'(b1.Dout),   32'h2AB);
      check("rdw_m1_dvalid", 32'(b1.DVALID), 32'd1);
      check("rdw_s2_dout",   32'(b2.Dout),   32'h155);
      check("rdw_s2_dvalid", 32'(b2.DVALID), 32'd1);

      // u0 idle (hold), u2 writes out of range
      b0.EN = 1'b0; b1.EN = 1'b0;
      b2.WE = 1'b1; b2.ADDR = 8'd210; b2.Din = 10'h3FF;
      tick();
      check("hold_m0_dvalid", 32'(b0.DVALID), 32'd0);
      check("hold_m0_dout",   32'(b0.Dout),   32'h2AB);
      check("oor_wr_dvalid",  32'(b2.DVALID), 32'd0);
      check("oor_wr_dout",    32'(b2.Dout),   32'h155);
      b2.WE = 1'b0;
      tick();
      check("oor_rd_dout",   32'(b2.Dout),   32'd0);
      check("oor_rd_dvalid", 32'(b2.DVALID), 32'd1);
      idle_all();

      // Fill 0..3, then CLR together with a write to 9
      b0.EN = 1'b1; b0.WE = 1'b1;
      for (int k = 0; k < 4; k++) begin
         b0.ADDR = 8'(k);
         b0.Din  = 10'(k + 1);
         tick();
      end
      b0.WE = 1'b0; b0.ADDR = 8'd3;
      tick();
      check("fill_rd3_dout", 32'(b0.Dout), 32'd4);
      b0.EN = 1'b1; b0.WE = 1'b1; b0.ADDR = 8'd9; b0.Din = 10'd7; b0.CLR = 1'b1;
      tick();
      check("clr_win_busy",   32'(b0.BUSY),   32'd1);
      check("clr_win_dvalid", 32'(b0.DVALID), 32'd0);
      observe(260, -1, -1);
      check("clr_busy_len", 32'(busy0), 32'd256);
      check("clr_done",     32'(done0), 32'd1);
      check("clr_dvalid",   32'(dval0), 32'd0);
      read0(8'd0, 10'd0, "clr_rd0");
      read0(8'd1, 10'd0, "clr_rd1");
      read0(8'd2, 10'd0, "clr_rd2");
      read0(8'd3, 10'd0, "clr_rd3");
      read0(8'd9, 10'd0, "clr_rd9");

      // CLR and a write injected during a running clear
      b0.CLR = 1'b1;
      tick();
      observe(260, 100, 150);
      check("noext_busy_len", 32'(busy0), 32'd256);
      check("noext_done",     32'(done0), 32'd1);
      check("noext_dvalid",   32'(dval0), 32'd0);
      read0(8'd5, 10'd0, "noext_rd5");

      // Reset in the middle of a clear
      b0.EN = 1'b1; b0.WE = 1'b1; b0.ADDR = 8'd5; b0.Din = 10'h2AB;
      tick();
      read0(8'd5, 10'h2AB, "pre_rst_rd5");
      b0.CLR = 1'b1;
      tick();
      b0.CLR = 1'b0;
      repeat (50) tick();
      RST_N = 1'b0;
      #1;
      check("midrst_dout",   32'(b0.Dout),   32'd0);
      check("midrst_dvalid", 32'(b0.DVALID), 32'd0);
      check("midrst_busy",   32'(b0.BUSY),   32'd1);
      tick();
      tick();
      RST_N = 1'b1;
      observe(260, -1, -1);
      check("rerun_busy_len0", 32'(busy0), 32'd256);
      check("rerun_done0",     32'(done0), 32'd1);
      check("rerun_busy_len2", 32'(busy2), 32'd200);
      read0(8'd5, 10'd0, "rerun_rd5");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_clr.md
RAM_CLR -- requirements
Module: ram_clr

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, address bus width in bits.
REQ-002 Parameter DATA_WIDTH, default 10, word width in bits.
REQ-003 Parameter MEM_SIZE, default 256, number of words; SHALL satisfy 2 <= MEM_SIZE <= 2**ADDR_WIDTH.
REQ-004 Parameter RDW_MODE, default 0, write behaviour of Dout: 0 = Dout unchanged on write, 1 = write-through (Dout <= Din).
REQ-005 CLK  input  1  single clock, all logic on rising edge.
REQ-006 RST_N  input  1  asynchronous, active-low reset.
REQ-007 EN  input  1  access enable.
REQ-008 WE  input  1  write enable, qualified by EN.
REQ-009 ADDR  input  ADDR_WIDTH  word address.
REQ-010 Din  input  DATA_WIDTH  write data.
REQ-011 CLR  input  1  request to zero the whole array, sampled in IDLE only.
REQ-012 Dout  output  DATA_WIDTH  registered read data, driven at all times, never high-impedance.
REQ-013 DVALID  output  1  one-cycle pulse marking new Dout data.
REQ-014 BUSY  output  1  high while the clear engine owns the array.
REQ-015 DONE  output  1  one-cycle pulse after the last word of a clear has been written.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE (user access) and CLEAR (sequential zeroing).
REQ-017 In CLEAR, each cycle SHALL write 0 to MEM[cnt] and increment cnt (ADDR_WIDTH bits); on cnt == MEM_SIZE-1 it SHALL write that word, return to IDLE and zero cnt.
REQ-018 A clear SHALL take exactly MEM_SIZE cycles; BUSY SHALL be high for exactly those cycles.
REQ-019 DONE SHALL pulse high for one cycle, on the first IDLE cycle after a clear.
REQ-020 CLR high in IDLE SHALL enter CLEAR on the next edge; CLR in CLEAR SHALL be ignored, with no restart and no extension.
REQ-021 CLR and EN high together in IDLE: CLR SHALL win and the access SHALL be dropped (no write, DVALID low).
REQ-022 While BUSY, EN/WE SHALL be ignored; DVALID SHALL stay low and Dout SHALL hold.
REQ-023 Read (IDLE, EN=1, WE=0): Dout SHALL equal MEM[ADDR] and DVALID SHALL be 1 one cycle after the request edge; latency 1, full throughput (back-to-back reads give one result per cycle).
REQ-024 Write (IDLE, EN=1, WE=1): MEM[ADDR] <= Din at the edge. RDW_MODE=0: Dout holds and DVALID is 0. RDW_MODE=1: Dout <= Din and DVALID is 1 the next cycle.
REQ-025 Read of an address just written in the previous cycle SHALL return the new data.
REQ-026 ADDR >= MEM_SIZE: the write SHALL be dropped with no array change; a read SHALL return all-zero with DVALID=1.
REQ-027 With EN low, Dout SHALL hold its last value and DVALID SHALL be 0.

Reset
REQ-028 RST_N low SHALL asynchronously force Dout=0, DVALID=0, DONE=0, cnt=0 and state=CLEAR; BUSY SHALL read 1 during reset.
REQ-029 On RST_N release, a full MEM_SIZE-cycle clear SHALL run automatically, so the array is all-zero before the first user access.
REQ-030 Reset asserted mid-clear or mid-access SHALL abandon the operation; the clear SHALL restart from address 0 after release.
REQ-031 The array contents themselves are not reset asynchronously; they are zeroed only by the clear engine.

Verification
REQ-032 Release RST_N with default parameters -> BUSY high for 256 cycles, DONE pulses once, read of addresses 0, 127 and 255 -> Dout=0, DVALID=1.
REQ-033 Write 0x2AB to address 5, then read address 5 on the next cycle -> Dout=0x2AB one cycle after the read, DVALID pulse of 1 cycle; with RDW_MODE=1 the write cycle also yields Dout=0x2AB, DVALID=1.
REQ-034 Fill addresses 0..3 with 1..4, pulse CLR together with EN=1 WE=1 ADDR=9 Din=7 -> the write is dropped, BUSY for 256 cycles, then addresses 0..3 and 9 all read 0.
REQ-035 During a clear, drive CLR again at cycle 100 and EN=1 WE=1 at cycle 150 -> clear length is still 256 cycles, DVALID stays 0, DONE pulses once.
REQ-036 Assert RST_N low at clear cycle 50 for 2 cycles -> Dout=0 and DVALID=0 at once, and a fresh 256-cycle clear starts after release.
REQ-037 MEM_SIZE=200, ADDR_WIDTH=8: write 0x3FF to address 210, then read address 210 -> Dout=0, DVALID=1; clear length is 200 cycles.
